// File: rtl/seq_addsub.sv
// seq_addsub: multi-cycle adder/subtractor for the calculator datapath.
// A WIDTH-bit operand pair is consumed CHUNK bits per clock, least
// significant chunk first, with the inter-chunk carry held in a register.
// Results and flags are registered and only change when an operation
// completes, so the display path never sees a partially built sum.

module seq_addsub #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             sub_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] s_o,
  output logic             c_o,
  output logic             ovf_o,
  output logic             zero_o
);

  localparam int NCHUNK = WIDTH / CHUNK;
  // A single-chunk configuration still needs a one-bit counter.
  localparam int CW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST_CHUNK = CW'(NCHUNK - 1);

  // Refuse to build a configuration that cannot split the word evenly.
  generate
    if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : gBadChunk
      $error("seq_addsub: WIDTH must be a non-zero multiple of CHUNK");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q;

  // Operand shift registers; the low chunk is always the one being added.
  logic [WIDTH-1:0] aOp_q;
  logic [WIDTH-1:0] bOp_q;
  logic [WIDTH-1:0] aOp_d;
  logic [WIDTH-1:0] bOp_d;

  // Result assembly register, filled from the MSB side one chunk at a time.
  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] shift_d;

  logic             carry_q;
  logic [CW-1:0]    cnt_q;

  // Registered handshake and result outputs.
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] s_q;
  logic             c_q;
  logic             ovf_q;
  logic             zero_q;

  // Chunk datapath signals.
  logic [CHUNK:0]        chunkFull;
  logic [CHUNK-1:0]      chunkSum;
  logic                  chunkCarry;
  logic                  msbCarryIn;
  logic                  ovf_d;
  logic                  zero_d;
  logic [WIDTH+CHUNK-1:0] shiftWide;
  logic [WIDTH+CHUNK-1:0] aWide;
  logic [WIDTH+CHUNK-1:0] bWide;

  // One chunk of ripple addition plus the shifted views of the operand and
  // result registers; the carry into the chunk MSB is recovered from the
  // sum bit, which keeps the overflow term correct for any CHUNK (even 1).
  always_comb begin
    chunkFull  = {1'b0, aOp_q[CHUNK-1:0]}
               + {1'b0, bOp_q[CHUNK-1:0]}
               + (CHUNK+1)'(carry_q);
    chunkSum   = chunkFull[CHUNK-1:0];
    chunkCarry = chunkFull[CHUNK];
    msbCarryIn = aOp_q[CHUNK-1] ^ bOp_q[CHUNK-1] ^ chunkSum[CHUNK-1];
    ovf_d      = msbCarryIn ^ chunkCarry;

    shiftWide  = {chunkSum, shift_q};
    shift_d    = shiftWide[WIDTH+CHUNK-1:CHUNK];

    aWide      = {{CHUNK{1'b0}}, aOp_q};
    bWide      = {{CHUNK{1'b0}}, bOp_q};
    aOp_d      = aWide[WIDTH+CHUNK-1:CHUNK];
    bOp_d      = bWide[WIDTH+CHUNK-1:CHUNK];

    zero_d     = ~|shift_d;
  end

  // Control FSM together with the operand, carry and result registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      aOp_q   <= '0;
      bOp_q   <= '0;
      shift_q <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      s_q     <= '0;
      c_q     <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (start_i) begin
            aOp_q   <= a_i;
            bOp_q   <= sub_i ? ~b_i : b_i;
            carry_q <= sub_i;
            shift_q <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end else begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end

        RUN: begin
          aOp_q   <= aOp_d;
          bOp_q   <= bOp_d;
          shift_q <= shift_d;
          carry_q <= chunkCarry;
          if (cnt_q == LAST_CHUNK) begin
            s_q     <= shift_d;
            c_q     <= chunkCarry;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            cnt_q   <= '0;
            state_q <= DONE;
          end else begin
            cnt_q   <= cnt_q + CW'(1);
          end
        end

        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign s_o    = s_q;
  assign c_o    = c_q;
  assign ovf_o  = ovf_q;
  assign zero_o = zero_q;

endmodule

// File: doc/seq_addsub.md
Name: seq_addsub

Overview:
- Multi-cycle, parametrised adder/subtractor for the calculator datapath.
- Processes a WIDTH-bit operand pair CHUNK bits per clock, rippling the carry between chunks through a register.
- Uses a start/busy/done handshake and returns sum, carry, signed overflow and zero flags.
- Sits between operand registers and the result/display path; trades latency for a narrow carry chain.

Parameters:
WIDTH, 16, operand and result width in bits
CHUNK, 4, bits processed per clock; WIDTH % CHUNK == 0 required (elaboration error otherwise); CHUNK == WIDTH is legal

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  asynchronous reset, active-high
start_i  input  1  request; sampled only when busy_o == 0
sub_i  input  1  0 = a_i + b_i, 1 = a_i - b_i; sampled with start_i
a_i  input  WIDTH  operand A, sampled with start_i
b_i  input  WIDTH  operand B, sampled with start_i
busy_o  output  1  operation in progress
done_o  output  1  one-cycle pulse; results valid
s_o  output  WIDTH  result (sum or difference), registered
c_o  output  1  carry out of MSB (for subtract: 1 = no borrow)
ovf_o  output  1  two's-complement signed overflow
zero_o  output  1  s_o == 0

Behaviour:
- NCHUNK = WIDTH/CHUNK. States: IDLE, RUN, DONE.
- Reset (async, any state): state=IDLE, all outputs 0, internal operand/shift/carry registers 0. Release is synchronous to the next edge; no operation resumes.
- Accept:
  - Edge E0 with busy_o==0 (IDLE or DONE) and start_i==1 captures operands into internal registers.
  - Subtract captures B as ~b_i and sets carry-in = 1. Add captures b_i with carry-in = 0.
  - State goes to RUN and busy_o=1.
- RUN:
  - Each edge E1..E_NCHUNK adds the low CHUNK bits of A, B and the carry register.
  - The chunk result is shifted into the result shift register from the MSB side.
  - A and B shift right by CHUNK, and the carry register takes the chunk carry-out.
  - A chunk counter counts 0..NCHUNK-1.
- Completion:
  - At edge E_NCHUNK the state goes to DONE. s_o, c_o, ovf_o and zero_o load from the final values, busy_o=0 and done_o=1.
  - Latency is exactly NCHUNK edges from the start edge to done_o high.
- DONE lasts one cycle, then the state returns to IDLE and done_o=0.
  - A start_i seen in the DONE cycle is accepted; the state goes straight to RUN and done_o drops.
- Outputs s_o/c_o/ovf_o/zero_o change only at completion. They hold the last result until the next completion or reset, and never show partial results.
- start_i while busy_o==1 is ignored. a_i/b_i/sub_i changes during RUN have no effect.
- Flags:
  - ovf_o = carry into MSB XOR carry out of MSB, computed inside the final chunk.
  - c_o = final carry-out, not inverted for subtract.
  - zero_o = ~|s_o, registered with s_o.
- Arithmetic is modulo 2^WIDTH with no saturation.

Test Plan:
- Reset, WIDTH=16/CHUNK=4: assert rst_i mid-cycle → all outputs 0 immediately (asynchronous), busy_o=0, done_o never pulses.
- Add, start at E0 with a=0x1234, b=0x4321:
  - busy_o=1 after E0..E3.
  - At E4: done_o=1 for one cycle, s_o=0x5555, c_o=0, ovf_o=0, zero_o=0.
- Add 0xFFFF+0x0001 → s_o=0x0000, c_o=1, zero_o=1, ovf_o=0. Add 0x7FFF+0x0001 → s_o=0x8000, c_o=0, ovf_o=1.
- Subtract:
  - 0x8000-0x0001 → s_o=0x7FFF, c_o=1, ovf_o=1.
  - 0x0003-0x0005 → s_o=0xFFFE, c_o=0, ovf_o=0.
  - 0x00AA-0x00AA → s_o=0, c_o=1, zero_o=1.
- Handshake:
  - Pulse start_i at E1 and E2 of a running op with different operands → ignored; result matches the first op.
  - Hold start_i=1 through the DONE cycle → second op accepted; its done_o arrives 4 edges later with correct result; first result stable until then.
- Reset mid-RUN after E2, then a new add 0x0001+0x0001 → no stale done_o; new result s_o=0x0002 after 4 edges. Repeat with CHUNK=16 (latency 1) and CHUNK=1 (latency 16) using the same vectors.
